// File: rtl/spi_slave_fd.sv
// spi_slave_fd
//   Full-duplex SPI slave with configurable word width and bit order.
//   All pin inputs are sampled on the rising edge of sync_clock.
//   A one-word tx buffer is written through a valid/ready handshake.
//   That word is moved into the tx shift register when a frame starts.
//
// Parameters
//   WIDTH      bits per frame (2..32)
//   LSB_FIRST  1: bit 0 travels first (right shift); 0: bit WIDTH-1 first
//   IDLE_WORD  word shifted out when a frame starts with the tx buffer empty
//
// Ports
//   sync_clock  in   clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   CS          in   chip select, active low
//   MOSI        in   serial data in
//   MISO        out  serial data out, 0 outside SHIFT
//   tx_data     in   word for the next frame
//   tx_valid    in   tx_data valid
//   tx_ready    out  tx buffer empty
//   rx_data     out  last complete received word
//   rx_valid    out  1-cycle pulse, rx_data updated
//   aborted     out  1-cycle pulse, CS released mid-frame
//   underrun    out  1-cycle pulse, frame started with empty tx buffer
module spi_slave_fd #(
  parameter int               WIDTH     = 12,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic             sync_clock,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             aborted,
  output logic             underrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rx_sh;
  logic [WIDTH-1:0] r_tx_sh;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_full;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_aborted;
  logic             r_underrun;

  logic w_start;
  logic w_sample;
  logic w_abort;
  logic w_last;

  assign w_start  = (r_state == ST_IDLE)  && !CS;
  assign w_sample = (r_state == ST_SHIFT) && !CS;
  assign w_abort  = (r_state == ST_SHIFT) &&  CS;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge sync_clock or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!CS) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (CS)          w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_IDLE;  // CS deliberately ignored here
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sync_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_aborted  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rx_valid <= (r_state == ST_DONE);
      r_aborted  <= w_abort;
      r_underrun <= w_start && !r_tx_full;

      if (w_start) begin
        r_cnt   <= '0;
        r_rx_sh <= '0;
        r_tx_sh <= r_tx_full ? r_tx_buf : IDLE_WORD;
      end else if (w_sample) begin
        r_cnt <= r_cnt + CW'(1);
        if (LSB_FIRST) begin
          r_rx_sh <= {MOSI, r_rx_sh[WIDTH-1:1]};
          r_tx_sh <= {1'b0, r_tx_sh[WIDTH-1:1]};
        end else begin
          r_rx_sh <= {r_rx_sh[WIDTH-2:0], MOSI};
          r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
        end
      end

      if (r_state == ST_DONE) r_rx_data <= r_rx_sh;

      // A write landing on a frame-start edge with an empty buffer is not
      // bypassed into the shift register; it waits for the next frame.
      if (w_start && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (tx_valid && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_buf  <= tx_data;
      end
    end
  end

  assign MISO     = (r_state == ST_SHIFT) ?
                    (LSB_FIRST ? r_tx_sh[0] : r_tx_sh[WIDTH-1]) : 1'b0;
  assign tx_ready = !r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign aborted  = r_aborted;
  assign underrun = r_underrun;

endmodule
